// File: rtl/mm_tile_sched_if.sv
// Bundled command, buffer-read, datapath and result signals of the tile scheduler.
// The slave modport is the scheduler's view; the master modport is its environment.
interface mm_tile_sched_if #(
    parameter int N  = 16,
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int CW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CW-1:0]   cmd_k_tiles;
    logic [CW-1:0]   cmd_row_blocks;
    logic [AW-1:0]   cmd_w_base;
    logic [AW-1:0]   cmd_v_base;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_addr;
    logic            v_rd_en;
    logic [AW-1:0]   v_rd_addr;
    logic            mm_input_valid;
    logic            mm_add_valid;
    logic [DW*N-1:0] mm_vector_output;
    logic            res_valid;
    logic            res_ready;
    logic [DW*N-1:0] res_data;
    logic [CW-1:0]   res_row;
    logic            busy;
    logic            done;

    modport master (
        output cmd_valid, cmd_k_tiles, cmd_row_blocks, cmd_w_base, cmd_v_base,
        output mm_add_valid, mm_vector_output, res_ready,
        input  cmd_ready, w_rd_en, w_rd_addr, v_rd_en, v_rd_addr, mm_input_valid,
        input  res_valid, res_data, res_row, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_k_tiles, cmd_row_blocks, cmd_w_base, cmd_v_base,
        input  mm_add_valid, mm_vector_output, res_ready,
        output cmd_ready, w_rd_en, w_rd_addr, v_rd_en, v_rd_addr, mm_input_valid,
        output res_valid, res_data, res_row, busy, done
    );
endinterface

// File: rtl/mm_tile_sched.sv
// Tiled matrix-vector sequencer: issues weight/vector read pairs row-major,
// accumulates K partial vectors per row block and returns each row over valid/ready.
module mm_tile_sched #(
    parameter int N       = 16,
    parameter int DW      = 32,
    parameter int AW      = 10,
    parameter int CW      = 8,
    parameter int MAX_OUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mm_tile_sched_if.slave bus
);
    localparam int OW = $clog2(MAX_OUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   k_tiles;
    logic [CW-1:0]   row_blocks;
    logic [AW-1:0]   v_base;
    logic [AW-1:0]   w_addr;
    logic [CW-1:0]   issue_k;
    logic [CW-1:0]   issue_r;
    logic            issued_all;
    logic [OW-1:0]   outstanding;
    logic            final_out;
    logic            mm_valid_q;
    logic [CW-1:0]   acc_k;
    logic [CW-1:0]   acc_r;
    logic [DW*N-1:0] acc;
    logic [DW*N-1:0] sum;
    logic            res_valid_q;
    logic [DW*N-1:0] res_data_q;
    logic [CW-1:0]   res_row_q;
    logic [CW-1:0]   res_cnt;

    logic take;
    logic issue;
    logic issue_final;
    logic add;
    logic last_k;
    logic res_hs;

    assign take        = bus.cmd_valid && (state == S_IDLE);
    assign issue_final = (issue_k == k_tiles - CW'(1));
    assign add         = bus.mm_add_valid && (state == S_RUN);
    assign last_k      = (acc_k == k_tiles - CW'(1));
    assign res_hs      = res_valid_q && bus.res_ready;

    // A final tile waits until the result register is free and no other row's
    // final partial sum is in flight, so a returning sum always has a slot.
    always_comb begin
        issue = (state == S_RUN) && !issued_all && (outstanding != OW'(MAX_OUT));
        if (issue_final && (res_valid_q || final_out))
            issue = 1'b0;
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (acc_k == '0)
                sum[i*DW +: DW] = bus.mm_vector_output[i*DW +: DW];
            else
                sum[i*DW +: DW] = acc[i*DW +: DW] + bus.mm_vector_output[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k_tiles     <= '0;
            row_blocks  <= '0;
            v_base      <= '0;
            w_addr      <= '0;
            issue_k     <= '0;
            issue_r     <= '0;
            issued_all  <= 1'b0;
            outstanding <= '0;
            final_out   <= 1'b0;
            mm_valid_q  <= 1'b0;
            acc_k       <= '0;
            acc_r       <= '0;
            acc         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_cnt     <= '0;
        end else begin
            mm_valid_q <= issue;

            case ({issue, add})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase

            if (issue && issue_final)
                final_out <= 1'b1;
            else if (add && last_k)
                final_out <= 1'b0;

            // w_base + r*K + k advances by exactly one per issue in row-major order
            if (issue) begin
                w_addr <= w_addr + AW'(1);
                if (issue_final) begin
                    issue_k <= '0;
                    issue_r <= issue_r + CW'(1);
                    if (issue_r == row_blocks - CW'(1))
                        issued_all <= 1'b1;
                end else begin
                    issue_k <= issue_k + CW'(1);
                end
            end

            if (res_hs) begin
                res_valid_q <= 1'b0;
                res_cnt     <= res_cnt + CW'(1);
            end

            if (add) begin
                if (last_k) begin
                    res_data_q  <= sum;
                    res_row_q   <= acc_r;
                    res_valid_q <= 1'b1;
                    acc_k       <= '0;
                    acc_r       <= acc_r + CW'(1);
                end else begin
                    acc   <= sum;
                    acc_k <= acc_k + CW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (take) begin
                        k_tiles    <= bus.cmd_k_tiles;
                        row_blocks <= bus.cmd_row_blocks;
                        v_base     <= bus.cmd_v_base;
                        w_addr     <= bus.cmd_w_base;
                        issue_k    <= '0;
                        issue_r    <= '0;
                        issued_all <= 1'b0;
                        acc_k      <= '0;
                        acc_r      <= '0;
                        res_cnt    <= '0;
                        if ((bus.cmd_k_tiles == '0) || (bus.cmd_row_blocks == '0))
                            state <= S_FIN;
                        else
                            state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (res_hs && (res_cnt == row_blocks - CW'(1)))
                        state <= S_FIN;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.busy           = (state != S_IDLE);
    assign bus.done           = (state == S_FIN);
    assign bus.w_rd_en        = issue;
    assign bus.v_rd_en        = issue;
    assign bus.w_rd_addr      = w_addr;
    assign bus.v_rd_addr      = v_base + AW'(issue_k);
    assign bus.mm_input_valid = mm_valid_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_row        = res_row_q;
endmodule

// File: tb/tb_mm_tile_sched.sv
// Self-checking bench for mm_tile_sched: command table, randomized commands and
// reset/injection sequences against a datapath model and a row-sum reference.
module tb_mm_tile_sched;
    localparam int N = 16, DW = 32, AW = 10, CW = 8, MAX_OUT = 8;
    localparam int VW = DW * N;
    localparam int AMASK = (1 << AW) - 1;

    typedef struct {
        int k, r, wb, vb, lat, stall, rnd, mode;
        int exp_reads, exp_res, exp_max;
        logic [31:0] exp_lane;
    } vec_t;

    typedef struct {
        int          due;
        logic [VW-1:0] d;
        bit          fin;
    } dp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_tile_sched_if #(.N(N), .DW(DW), .AW(AW), .CW(CW)) bus ();

    mm_tile_sched #(.N(N), .DW(DW), .AW(AW), .CW(CW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    int cur_k, cur_r, cur_wb, cur_vb, cur_lat = 1, cur_mode, stall_cnt = 0, rnd_ready = 0;
    bit inject = 0;
    int n_reads, n_res, first_issue = -1, first_miv = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
    int max_out = 0, tb_out = 0, finals_out = 0, final_add_cyc = -10;
    bit prev_wen = 0, prev_rv = 0, hold = 0;
    logic [VW-1:0] hold_data, last_data;
    logic [CW-1:0] hold_row;
    int exp_w[$], exp_v[$], exp_row[$], rd_w[$], rd_v[$];
    logic [VW-1:0] exp_res[$];
    dp_t dp_q[$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_val(int mode, int r, int k, int i);
        case (mode)
            0:       return 32'd5;
            1:       return 32'(100 * r + k);
            default: return (32'(r + 1) * 32'h9E3779B1) ^ (32'(k + 3) * 32'h85EBCA77) ^ (32'(i + 1) * 32'hC2B2AE3D);
        endcase
    endfunction

    function automatic logic [VW-1:0] tile_vec(int mode, int r, int k);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = lane_val(mode, r, k, i);
        return v;
    endfunction

    // Expected row result: plain per-lane sum of all K tiles, wrapping at 32 bits.
    function automatic logic [VW-1:0] row_sum(int mode, int r, int kt);
        logic [VW-1:0] v;
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            s = '0;
            for (int k = 0; k < kt; k++) s = s + lane_val(mode, r, k, i);
            v[i*DW +: DW] = s;
        end
        return v;
    endfunction

    // Environment: result-ready policy, read/result monitors and datapath model.
    always @(negedge clk) begin
        int w, v, j, kk, rr;
        dp_t e;
        cyc++;
        if (rst_n) begin
            if (bus.res_valid && stall_cnt > 0) begin
                bus.res_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.res_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end

            check("rd_en_pair", bus.v_rd_en, bus.w_rd_en);
            check("miv_delay", bus.mm_input_valid, prev_wen);
            prev_wen = bus.w_rd_en;

            if (bus.w_rd_en) begin
                w = int'(bus.w_rd_addr);
                v = int'(bus.v_rd_addr);
                n_reads++;
                if (n_reads == 1) first_issue = cyc;
                if (exp_w.size() == 0) check("extra_read", 1'b1, 1'b0);
                else begin
                    check("w_rd_addr", w, exp_w.pop_front());
                    check("v_rd_addr", v, exp_v.pop_front());
                end
                kk = (v - cur_vb) & AMASK;
                if (kk == cur_k - 1) begin
                    check("final_gate_res", bus.res_valid, 1'b0);
                    check("final_gate_out", finals_out, 0);
                    finals_out++;
                end
                tb_out++;
                if (tb_out > max_out) max_out = tb_out;
                check("outstanding_cap", tb_out <= MAX_OUT, 1'b1);
                rd_w.push_back(w);
                rd_v.push_back(v);
            end

            if (bus.mm_input_valid) begin
                if (first_miv < 0) first_miv = cyc;
                if (rd_w.size() > 0 && cur_k > 0) begin
                    w  = rd_w.pop_front();
                    v  = rd_v.pop_front();
                    j  = (w - cur_wb) & AMASK;
                    kk = (v - cur_vb) & AMASK;
                    rr = (j - kk) / cur_k;
                    e.due = cyc + cur_lat;
                    e.d   = tile_vec(cur_mode, rr, kk);
                    e.fin = (kk == cur_k - 1);
                    dp_q.push_back(e);
                end
            end

            bus.mm_add_valid = 1'b0;
            if (dp_q.size() > 0 && dp_q[0].due == cyc) begin
                bus.mm_add_valid     = 1'b1;
                bus.mm_vector_output = dp_q[0].d;
                tb_out--;
                if (dp_q[0].fin) begin
                    finals_out--;
                    final_add_cyc = cyc;
                end
                dp_q.delete(0);
            end else if (inject) begin
                bus.mm_add_valid     = 1'b1;
                bus.mm_vector_output = '1;
                inject = 0;
            end

            if (bus.res_valid && !prev_rv) check("res_valid_rise", final_add_cyc, cyc - 1);
            if (hold) begin
                check("hold_valid", bus.res_valid, 1'b1);
                check("hold_data", bus.res_data, hold_data);
                check("hold_row", bus.res_row, hold_row);
            end
            hold = 0;
            if (bus.res_valid) begin
                if (bus.res_ready) begin
                    n_res++;
                    last_hs   = cyc;
                    last_data = bus.res_data;
                    if (exp_res.size() == 0) check("extra_result", 1'b1, 1'b0);
                    else begin
                        check("res_data", bus.res_data, exp_res.pop_front());
                        check("res_row", bus.res_row, exp_row.pop_front());
                    end
                end else begin
                    hold      = 1;
                    hold_data = bus.res_data;
                    hold_row  = bus.res_row;
                end
            end
            prev_rv = bus.res_valid;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_res_valid"}, bus.res_valid, 1'b0);
        check({tag, "_w_rd_en"}, bus.w_rd_en, 1'b0);
        check({tag, "_v_rd_en"}, bus.v_rd_en, 1'b0);
        check({tag, "_miv"}, bus.mm_input_valid, 1'b0);
        check({tag, "_res_data"}, bus.res_data, '0);
        check({tag, "_res_row"}, bus.res_row, '0);
        check({tag, "_w_rd_addr"}, bus.w_rd_addr, '0);
        check({tag, "_v_rd_addr"}, bus.v_rd_addr, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_w.delete(); exp_v.delete(); exp_res.delete(); exp_row.delete();
        rd_w.delete(); rd_v.delete(); dp_q.delete();
        tb_out = 0; finals_out = 0; prev_wen = 0; prev_rv = 0; hold = 0; stall_cnt = 0;
        bus.mm_add_valid = 1'b0;
        bus.cmd_valid    = 1'b0;
        #1;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic setup(input vec_t t);
        cur_k = t.k; cur_r = t.r; cur_wb = t.wb; cur_vb = t.vb; cur_lat = t.lat;
        cur_mode = t.mode; stall_cnt = t.stall; rnd_ready = t.rnd;
        if (t.k > 0 && t.r > 0) begin
            for (int r = 0; r < t.r; r++) begin
                for (int k = 0; k < t.k; k++) begin
                    exp_w.push_back((t.wb + r * t.k + k) % (1 << AW));
                    exp_v.push_back((t.vb + k) % (1 << AW));
                end
                exp_res.push_back(row_sum(t.mode, r, t.k));
                exp_row.push_back(r);
            end
        end
        n_reads = 0; n_res = 0; first_issue = -1; first_miv = -1; max_out = 0;
        done_cnt = 0; last_hs = -1; done_cyc = -1;
    endtask

    task automatic drive_cmd(input vec_t t, output int t_acc);
        @(negedge clk);
        #1;
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid      = 1'b1;
        bus.cmd_k_tiles    = CW'(t.k);
        bus.cmd_row_blocks = CW'(t.r);
        bus.cmd_w_base     = AW'(t.wb);
        bus.cmd_v_base     = AW'(t.vb);
        t_acc = cyc;
        @(negedge clk);
        #1;
        check("busy_run", bus.busy, 1'b1);
        bus.cmd_valid      = $urandom_range(0, 1) == 1;
        bus.cmd_k_tiles    = CW'($urandom_range(0, 255));
        bus.cmd_row_blocks = CW'($urandom_range(0, 255));
        bus.cmd_w_base     = AW'($urandom_range(0, AMASK));
        bus.cmd_v_base     = AW'($urandom_range(0, AMASK));
    endtask

    task automatic apply(input vec_t t);
        int t_acc;
        logic [VW-1:0] ld;
        setup(t);
        drive_cmd(t, t_acc);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            @(negedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check("done_seen", done_cnt, 1);
        @(negedge clk);
        #1;
        check("done_pulse", done_cnt, 1);
        check("cmd_ready_after", bus.cmd_ready, 1'b1);
        check("busy_after", bus.busy, 1'b0);
        check("reads", n_reads, t.exp_reads);
        check("results", n_res, t.exp_res);
        if (t.exp_res > 0) begin
            check("done_cycle", done_cyc, last_hs + 1);
            check("first_read_cycle", first_issue, t_acc + 1);
            check("first_miv_cycle", first_miv, t_acc + 2);
            ld = last_data;
            check("last_lane0", ld[31:0], t.exp_lane);
        end else begin
            check("done_cycle_zero", done_cyc, t_acc + 1);
        end
        check("max_outstanding", max_out <= MAX_OUT, 1'b1);
        if (t.exp_max > 0) check("stall_at_cap", max_out, t.exp_max);
        check("pending_results", exp_res.size(), 0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t t;
        int t_acc;
        logic [VW-1:0] rs;

        vecs[0] = '{k:1,  r:1, wb:'h010, vb:'h020, lat:1,  stall:0,  rnd:0, mode:0, exp_reads:1,  exp_res:1, exp_max:0, exp_lane:32'd5};
        vecs[1] = '{k:4,  r:3, wb:'h3FE, vb:'h000, lat:1,  stall:0,  rnd:0, mode:1, exp_reads:12, exp_res:3, exp_max:0, exp_lane:32'd806};
        vecs[2] = '{k:4,  r:3, wb:'h3FE, vb:'h000, lat:1,  stall:20, rnd:0, mode:1, exp_reads:12, exp_res:3, exp_max:0, exp_lane:32'd806};
        vecs[3] = '{k:16, r:1, wb:'h040, vb:'h080, lat:12, stall:0,  rnd:0, mode:1, exp_reads:16, exp_res:1, exp_max:8, exp_lane:32'd120};
        vecs[4] = '{k:0,  r:5, wb:'h000, vb:'h000, lat:1,  stall:0,  rnd:0, mode:1, exp_reads:0,  exp_res:0, exp_max:0, exp_lane:32'd0};
        vecs[5] = '{k:5,  r:0, wb:'h123, vb:'h045, lat:1,  stall:0,  rnd:0, mode:1, exp_reads:0,  exp_res:0, exp_max:0, exp_lane:32'd0};
        vecs[6] = '{k:2,  r:2, wb:'h100, vb:'h3FF, lat:3,  stall:0,  rnd:0, mode:1, exp_reads:4,  exp_res:2, exp_max:0, exp_lane:32'd201};

        bus.cmd_valid = 1'b0; bus.cmd_k_tiles = '0; bus.cmd_row_blocks = '0;
        bus.cmd_w_base = '0; bus.cmd_v_base = '0; bus.mm_add_valid = 1'b0;
        bus.mm_vector_output = '0; bus.res_ready = 1'b1;

        do_reset();
        repeat (5) @(negedge clk);
        #1;
        check_idle("reset");

        for (int i = 0; i < 7; i++) apply(vecs[i]);

        // Reset mid-RUN drops the command; a stray add while idle must be ignored.
        t = vecs[1];
        setup(t);
        drive_cmd(t, t_acc);
        repeat (5) @(negedge clk);
        #1;
        do_reset_mid();
        check("no_done_on_reset", done_cnt, 0);
        inject = 1;
        apply('{k:2, r:1, wb:'h200, vb:'h010, lat:2, stall:0, rnd:0, mode:1, exp_reads:2, exp_res:1, exp_max:0, exp_lane:32'd1});

        for (int i = 0; i < 15; i++) begin
            t.k = $urandom_range(1, 6);
            t.r = $urandom_range(1, 4);
            t.wb = $urandom_range(0, AMASK);
            t.vb = $urandom_range(0, AMASK);
            t.lat = $urandom_range(1, 12);
            t.stall = 0; t.rnd = 1; t.mode = 2;
            t.exp_reads = t.k * t.r; t.exp_res = t.r; t.exp_max = 0;
            rs = row_sum(2, t.r - 1, t.k);
            t.exp_lane = rs[31:0];
            apply(t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic do_reset_mid();
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        do_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mm_tile_sched.md
# mm_tile_sched

Sequencer for the 16-lane matrix-vector datapath. Accepts a tiled matrix-vector command and issues one weight-tile/vector-tile read pair per cycle to the weight and vector buffers. It raises the datapath's input-valid aligned with the buffer read data, accumulates the K partial result vectors of each output row block, and hands completed row-block results downstream over a valid/ready port.

## Interface
- `N`, 16, lanes per vector (datapath width; fixed at 16).
- `DW`, 32, bits per lane.
- `AW`, 10, buffer address width.
- `CW`, 8, width of the tile and row-block counters.
- `MAX_OUT`, 8, maximum tiles issued but not yet returned on `mm_add_valid`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_k_tiles` in CW: K, the vector tiles per row block.
- `cmd_row_blocks` in CW: R, the output row blocks.
- `cmd_w_base` in AW / `cmd_v_base` in AW: weight and vector base addresses.
- `w_rd_en` out 1 / `w_rd_addr` out AW: weight buffer read (1-cycle read latency).
- `v_rd_en` out 1 / `v_rd_addr` out AW: vector buffer read (1-cycle read latency).
- `mm_input_valid` out 1: drives datapath input valid.
- `mm_add_valid` in 1 / `mm_vector_output` in DW*N: datapath result, in issue order.
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out DW*N / `res_row` out CW: result handshake.
- `busy` out 1: high while a command is active.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- States:
  - IDLE: `cmd_ready`=1. Accept moves to RUN, or to FIN if K=0 or R=0.
  - RUN: issue and accumulate. Moves to FIN when all R results have been accepted on the result port.
  - FIN: `done`=1 for one cycle, then IDLE.
- Command fields are latched on accept; input changes during RUN are ignored.
- Issue order is r = 0..R-1 (outer), k = 0..K-1 (inner), one pair per cycle.
  - `w_rd_addr` = w_base + r*K + k, modulo 2^AW.
  - `v_rd_addr` = v_base + k, modulo 2^AW.
  - `w_rd_en` and `v_rd_en` are always asserted together.
- `mm_input_valid` is `w_rd_en` delayed exactly one cycle.
- Outstanding counter: +1 on issue, -1 on `mm_add_valid`; both in the same cycle leaves it unchanged. No issue while the counter equals MAX_OUT.
- Final-tile gate: the k=K-1 tile of any row is not issued while `res_valid`=1, or while another row's final tile is outstanding. This guarantees the result register is free when each final partial sum arrives, so the datapath is never stalled.
- Accumulator (DW*N bits, per-lane two's-complement add, wraps modulo 2^DW, no saturation):
  - First result of a row loads the accumulator.
  - Each later result adds to it.
  - The K-th result loads `res_data` = acc + result and sets `res_valid`, with `res_row` = r.
  - K=1: `res_data` = the single result.
- `res_valid` holds, and `res_data`/`res_row` stay stable, until `res_ready` is sampled high.
- `mm_add_valid` in IDLE or FIN is ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: `cmd_ready`=1; all other outputs 0, including `res_data`, `res_row`, all addresses and all counters. State = IDLE.
- Accept at cycle T: first `w_rd_en`/`v_rd_en` at T+1, first `mm_input_valid` at T+2.
- With no stall, R*K issues occupy cycles T+1 .. T+R*K.
- The last result handshake at cycle H gives `done` at H+1 and `cmd_ready`=1 at H+2.
- Zero K or R: accept at T, `done` at T+1, no reads issued, no results produced.
- The accumulator updates on the clock edge that samples `mm_add_valid`.
- `res_valid` rises the cycle after the K-th `mm_add_valid` of a row.
- Reset asserted mid-command:
  - All state clears immediately and asynchronously.
  - Partial accumulations and pending results are discarded.
  - No `done` is produced.

## Test plan
- Reset, then idle 5 cycles: `cmd_ready`=1; `busy`, `done`, `res_valid`, `w_rd_en`, `mm_input_valid` all 0.
- K=1, R=1, bases 0x010/0x020, datapath model returns lanes = 5, `res_ready`=1:
  - Reads at addresses 0x010/0x020 at T+1.
  - `mm_input_valid` at T+2.
  - One result with all lanes 5 and `res_row`=0.
  - `done` one cycle after the result handshake.
- K=4, R=3, w_base=0x3FE, v_base=0, datapath returns lane value = 100*r + k:
  - Weight addresses run 0x3FE, 0x3FF, 0x000, ... (wrap).
  - Results have every lane 6, 406, 806 for rows 0, 1, 2, in order.
- Same command, `res_ready` held low for 20 cycles after the first `res_valid`:
  - `res_data` stays stable.
  - The row-1 final tile is not issued until the handshake.
  - No result is lost; the row-1 and row-2 results follow.
- K=16, R=1, datapath latency 12 cycles: outstanding never exceeds 8; issue stalls at 8 and resumes as results return.
- K=0, R=5 gives `done` at T+1 with no reads. K=4, R=3 with `rst_n` pulsed low mid-RUN: outputs return to reset values; a new K=2, R=1 command completes correctly.
